// File: rtl/mux_nx1_reg_if.sv
// Lane bus for mux_nx1_reg: flattened input lanes, select, clock enables and the selected result.
// SEL_ERR is present only when MUX_NX1_ILLEGAL_SEL_FLAG_EN is defined.
interface mux_nx1_reg_if #(
    parameter int WIDTH  = 48,
    parameter int NUM_IN = 8
);
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] IN;
    logic [SEL_W-1:0]        SEL;
    logic                    CESEL;
    logic                    CEOUT;
    logic [WIDTH-1:0]        OUT;
    logic [SEL_W-1:0]        SEL_Q;
`ifdef MUX_NX1_ILLEGAL_SEL_FLAG_EN
    logic                    SEL_ERR;

    modport master (output IN, SEL, CESEL, CEOUT, input OUT, SEL_Q, SEL_ERR);
    modport slave  (input IN, SEL, CESEL, CEOUT, output OUT, SEL_Q, SEL_ERR);
`else
    modport master (output IN, SEL, CESEL, CEOUT, input OUT, SEL_Q);
    modport slave  (input IN, SEL, CESEL, CEOUT, output OUT, SEL_Q);
`endif
endinterface

// File: rtl/mux_nx1_reg.sv
// N-input lane mux with optional select/output registers; MUX_NX1_ILLEGAL_SEL_FLAG_EN adds SEL_ERR.
// Latency: data SELREG-independent OUTREG cycles, select SELREG+OUTREG cycles.
// No backpressure: CESEL/CEOUT clock enables hold their registers.
module mux_nx1_reg #(
    parameter int WIDTH   = 48,
    parameter int NUM_IN  = 8,
    parameter int SELREG  = 1,
    parameter int OUTREG  = 1,
    parameter int RST_SEL = 0
) (
    input logic          CLK,
    input logic          RST,
    mux_nx1_reg_if.slave bus
);
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

    if (NUM_IN < 2) begin : g_bad_num_in
        $error("mux_nx1_reg: NUM_IN must be at least 2");
    end
    if (RST_SEL >= NUM_IN) begin : g_bad_rst_sel
        $error("mux_nx1_reg: RST_SEL must be below NUM_IN");
    end
    if (SELREG != 0 && SELREG != 1) begin : g_bad_selreg
        $error("mux_nx1_reg: SELREG must be 0 or 1");
    end
    if (OUTREG != 0 && OUTREG != 1) begin : g_bad_outreg
        $error("mux_nx1_reg: OUTREG must be 0 or 1");
    end

    logic [SEL_W-1:0] sel_q, sel_d, sel_eff;
    logic [WIDTH-1:0] out_q, out_d, mux_d;

    always_comb begin
        sel_eff = (SELREG == 1) ? sel_q : bus.SEL;
        sel_d   = bus.CESEL ? bus.SEL : sel_q;
        // Unmatched (illegal) selects fall through to zero data.
        mux_d   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_eff == SEL_W'(k)) begin
                mux_d = bus.IN[k*WIDTH +: WIDTH];
            end
        end
        out_d   = bus.CEOUT ? mux_d : out_q;
    end

`ifdef MUX_NX1_ILLEGAL_SEL_FLAG_EN
    logic err_q, err_d, sel_bad;

    always_comb begin
        sel_bad = (32'(sel_eff) >= 32'(NUM_IN));
        err_d   = bus.CEOUT ? sel_bad : err_q;
    end

    assign bus.SEL_ERR = (OUTREG == 1) ? err_q : sel_bad;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_q <= SEL_W'(RST_SEL);
            out_q <= '0;
`ifdef MUX_NX1_ILLEGAL_SEL_FLAG_EN
            err_q <= 1'b0;
`endif
        end else begin
            sel_q <= sel_d;
            out_q <= out_d;
`ifdef MUX_NX1_ILLEGAL_SEL_FLAG_EN
            err_q <= err_d;
`endif
        end
    end

    assign bus.OUT   = (OUTREG == 1) ? out_q : mux_d;
    assign bus.SEL_Q = sel_eff;
endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg: registered 8-lane, combinational 8-lane and registered 6-lane instances.
module tb_mux_nx1_reg;
    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    mux_nx1_reg_if #(.WIDTH(8), .NUM_IN(8)) ia ();
    mux_nx1_reg_if #(.WIDTH(8), .NUM_IN(8)) ib ();
    mux_nx1_reg_if #(.WIDTH(8), .NUM_IN(6)) ic ();

    mux_nx1_reg #(.WIDTH(8), .NUM_IN(8), .SELREG(1), .OUTREG(1), .RST_SEL(3))
        dut_a (.CLK(clk), .RST(rst), .bus(ia));
    mux_nx1_reg #(.WIDTH(8), .NUM_IN(8), .SELREG(0), .OUTREG(0), .RST_SEL(0))
        dut_b (.CLK(clk), .RST(rst), .bus(ib));
    mux_nx1_reg #(.WIDTH(8), .NUM_IN(6), .SELREG(1), .OUTREG(1), .RST_SEL(0))
        dut_c (.CLK(clk), .RST(rst), .bus(ic));

    localparam logic [63:0] L1 = 64'h1716151413121110;
    localparam logic [63:0] L2 = 64'hF0E1D2C3B4A59687;
    localparam logic [63:0] L3 = 64'h7766554433221100;
    localparam logic [47:0] LC = 48'h252423222120;

    typedef struct {
        logic [63:0] lanes;
        logic [2:0]  sel;
        logic [7:0]  exp;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{L1, 3'd0, 8'h10};
        vecs[1] = '{L1, 3'd5, 8'h15};
        vecs[2] = '{L1, 3'd7, 8'h17};
        vecs[3] = '{L2, 3'd0, 8'h87};
        vecs[4] = '{L2, 3'd3, 8'hB4};
        vecs[5] = '{L2, 3'd6, 8'hE1};
        vecs[6] = '{L2, 3'd7, 8'hF0};
        vecs[7] = '{L1, 3'd2, 8'h12};

        rst = 1'b1;
        ia.IN = L3;  ia.SEL = 3'd6; ia.CESEL = 1'b1; ia.CEOUT = 1'b1;
        ib.IN = L1;  ib.SEL = 3'd0; ib.CESEL = 1'b1; ib.CEOUT = 1'b1;
        ic.IN = LC;  ic.SEL = 3'd0; ic.CESEL = 1'b1; ic.CEOUT = 1'b1;

        // Reset state, then first capture through the reset select.
        tick();
        check("rst_out",     ia.OUT,   8'h00);
        check("rst_sel_q",   ia.SEL_Q, 3'd3);
        check("rst_c_out",   ic.OUT,   8'h00);
        check("rst_c_sel_q", ic.SEL_Q, 3'd0);
        rst = 1'b0;
        tick();
        check("post_rst_out",   ia.OUT,   8'h33);
        check("post_rst_sel_q", ia.SEL_Q, 3'd6);

        // Combinational instance: table of lane patterns, same-cycle result.
        for (int i = 0; i < 8; i++) begin
            ib.IN  = vecs[i].lanes;
            ib.SEL = vecs[i].sel;
            #1;
            check("comb_out",   ib.OUT,   vecs[i].exp);
            check("comb_sel_q", ib.SEL_Q, vecs[i].sel);
        end

        // Registered sweep: expected lane pushed at drive, popped two edges later.
        ia.IN = L1;
        for (int s = 0; s < 8; s++) begin
            ia.SEL = 3'(s);
            exp_q.push_back(8'h10 + 8'(s));
            tick();
            if (exp_q.size() == 2) check("sweep", ia.OUT, exp_q.pop_front());
        end
        tick();
        check("sweep_last", ia.OUT, exp_q.pop_front());

        // Clock-enable holds.
        ia.SEL = 3'd2;
        tick(); tick();
        check("ce_base_sel", ia.SEL_Q, 3'd2);
        check("ce_base_out", ia.OUT,   8'h12);
        ia.CESEL = 1'b0; ia.SEL = 3'd5;
        tick(); tick();
        check("cesel_hold_sel", ia.SEL_Q, 3'd2);
        check("cesel_hold_out", ia.OUT,   8'h12);
        ia.CEOUT = 1'b0; ia.CESEL = 1'b1;
        tick();
        check("ceout_sel_adv", ia.SEL_Q, 3'd5);
        tick();
        check("ceout_frozen", ia.OUT, 8'h12);
        ia.CEOUT = 1'b1;
        tick();
        check("ceout_resume", ia.OUT, 8'h15);

        // Reset mid-stream overrides enables and input activity.
        ia.SEL = 3'd1; tick();
        ia.SEL = 3'd4; tick();
        check("mid_pre_out", ia.OUT, 8'h11);
        rst = 1'b1; ia.SEL = 3'd6;
        tick();
        check("mid_rst_out",   ia.OUT,   8'h00);
        check("mid_rst_sel_q", ia.SEL_Q, 3'd3);
        rst = 1'b0; ia.SEL = 3'd7;
        tick();
        check("mid_first_out", ia.OUT,   8'h13);
        check("mid_first_sel", ia.SEL_Q, 3'd7);
        tick();
        check("mid_second_out", ia.OUT, 8'h17);

        // Simultaneous select and data change: old select sees new data first.
        ia.SEL = 3'd1;
        tick(); tick();
        check("simul_base", ia.OUT, 8'h11);
        ia.SEL = 3'd4; ia.IN = L2;
        tick();
        check("simul_old_sel", ia.OUT, 8'h96);
        tick();
        check("simul_new_sel", ia.OUT, 8'hC3);

        // Illegal select on the 6-lane instance.
        ic.SEL = 3'd7;
        tick(); tick();
        check("illegal_out", ic.OUT, 8'h00);
`ifdef MUX_NX1_ILLEGAL_SEL_FLAG_EN
        check("illegal_err", ic.SEL_ERR, 1'b1);
`endif
        ic.SEL = 3'd1;
        tick(); tick();
        check("legal_out", ic.OUT, 8'h21);
`ifdef MUX_NX1_ILLEGAL_SEL_FLAG_EN
        check("legal_err", ic.SEL_ERR, 1'b0);
`endif
        ic.SEL = 3'd5;
        tick(); tick();
        check("top_lane_out", ic.OUT, 8'h25);
        ic.SEL = 3'd6;
        tick(); tick();
        check("first_illegal_out", ic.OUT, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
- Parametrised successor to the fixed 8-input combinational mux: N-input, W-bit selector with optional select register and output register, each with its own clock enable.
- Matches the DSP48E1 OPMODE/INMODE pattern, where the select comes from a control register and the mux result feeds a pipeline register.
- Used for the X/Y/Z operand muxes and the ALUMODE-dependent result selection in the slice.

Parameters:
- WIDTH, 48, data width per input lane (1..64).
- NUM_IN, 8, number of input lanes (2..16); SEL_W = clog2(NUM_IN) (localparam, min 1).
- SELREG, 1, 1 = select registered (CESEL-gated); 0 = select used combinationally.
- OUTREG, 1, 1 = mux output registered (CEOUT-gated); 0 = output combinational.
- RST_SEL, 0, reset value of the select register; must be < NUM_IN.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset; clears the select and output registers.
- IN  input  NUM_IN*WIDTH  flattened lanes; lane k = IN[k*WIDTH +: WIDTH].
- SEL  input  SEL_W  lane select.
- CESEL  input  1  select-register clock enable (ignored when SELREG=0).
- CEOUT  input  1  output-register clock enable (ignored when OUTREG=0).
- OUT  output  WIDTH  selected lane.
- SEL_Q  output  SEL_W  effective select currently applied to the mux (debug/observability).

Behaviour:
- Effective select sel_eff:
  - SELREG=1: sel_eff = sel_reg.
  - SELREG=0: sel_eff = SEL.
- sel_reg update, on each rising CLK:
  - RST=1: sel_reg <= RST_SEL.
  - else if CESEL=1: sel_reg <= SEL.
  - else: hold.
- Mux result mux_d = lane[sel_eff] when sel_eff < NUM_IN; otherwise all zeros (illegal select; only possible when NUM_IN is not a power of 2).
- out_reg update, on each rising CLK:
  - RST=1: out_reg <= 0.
  - else if CEOUT=1: out_reg <= mux_d.
  - else: hold.
- OUT = out_reg when OUTREG=1; OUT = mux_d when OUTREG=0.
- SEL_Q = sel_eff.
- RST has priority over both CEs. Reset is synchronous: nothing changes until the clock edge on which RST=1 is sampled.
- Reset values:
  - OUTREG=1: OUT = 0.
  - OUTREG=0: OUT = lane[RST_SEL] after reset when SELREG=1.
  - SEL_Q = RST_SEL when SELREG=1.
- Latency:
  - Data path: IN -> OUT = OUTREG cycles.
  - Select path: SEL -> OUT = SELREG + OUTREG cycles.
- A select change and a data change in the same cycle with SELREG=1, OUTREG=1: the output edge registers the new data through the OLD select. The new select takes effect at the output one edge later.
- CESEL=1 with CEOUT=0: the select advances while OUT holds. Once CEOUT rises, OUT reflects the latest sel_reg.
- RST mid-stream: the next edge forces sel_reg=RST_SEL and out_reg=0, regardless of CEs or input activity. The first post-reset capture uses sel_eff=RST_SEL.
- Elaboration errors:
  - NUM_IN < 2.
  - RST_SEL >= NUM_IN.
  - SELREG or OUTREG not in {0,1}.
- No latches; all registers in one clocked process; fully synthesizable.

Optional Feature:
- Macro: MUX_NX1_ILLEGAL_SEL_FLAG_EN.
- Defined:
  - Adds output port SEL_ERR (1 bit).
  - SEL_ERR follows the same OUTREG staging and CEOUT gating as OUT.
  - SEL_ERR = 1 when the data captured/presented was produced with sel_eff >= NUM_IN; reset value 0.
- Undefined: port absent, no extra logic; illegal select still yields zero data.

Test Plan:
- Reset, WIDTH=8, NUM_IN=8, SELREG=1, OUTREG=1, RST_SEL=3 -> OUT=0x00 and SEL_Q=3 after the RST edge; with lane3=0x33 and CEOUT=1, OUT=0x33 one edge after RST drops.
- Sweep lanes k=0x10+k, SEL=0..7, CESEL=CEOUT=1 -> OUT equals 0x10+SEL exactly 2 edges after SEL is applied; with SELREG=0, OUTREG=0, OUT updates the same cycle.
- Clock-enable hold: CESEL=0 while SEL goes 2->5 -> SEL_Q stays 2 and OUT stays lane2. Then CEOUT=0 with CESEL=1 -> SEL_Q=5, OUT frozen. CEOUT=1 -> OUT=lane5 next edge.
- Illegal select, NUM_IN=6, SEL=7 -> OUT=0x00 after latency; with the macro defined, SEL_ERR=1 on the same cycle, and returns to 0 after SEL=1.
- Reset mid-stream with CESEL=CEOUT=1 and SEL toggling -> the RST edge forces OUT=0 and SEL_Q=RST_SEL, overriding enables; normal selection resumes the edge after RST drops.
- Simultaneous change: SEL 1->4 and all lanes change on the same edge -> the first OUT value is the new lane1 data, the next is the new lane4 data.
